keypad_entry: RTL

Front-end code collector that drives the lock's key/enter interface. It assembles two 4-bit keypad digits into an 8-bit code and issues a single-cycle enter strobe on submit. It also watches the lock's access/lockout feedback so it never strobes while the lock is settling, open or locked out. It sits between the keypad scanner and the digital lock.

---
 rtl/keypad_pkg.sv | 15 +
 rtl/entry_timer.sv | 31 +++
 rtl/keypad_entry.sv | 127 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared widths and FSM state encodings for the keypad code collector.
package keypad_pkg;

  localparam int NIBBLE_W = 4;
  localparam int CODE_W   = 8;
  localparam int TIMER_W  = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ONE     = 3'd1;
  localparam logic [2:0] S_TWO     = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_BLOCKED = 3'd5;

endpackage

// File: rtl/entry_timer.sv
// Idle counter for a partially or fully typed entry; expires after TIMEOUT_CYCLES cycles in ONE/TWO.
module entry_timer
  import keypad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] cnt;

  // Saturates at LAST so an expiry deferred by a rejected digit still fires next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || !run) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/keypad_entry.sv
// Collects two keypad digits into an 8-bit code and strobes it into the lock,
// holding off while the lock is settling, open or locked out.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                digit_valid,
  input  logic [NIBBLE_W-1:0] digit,
  input  logic                clear,
  input  logic                submit,
  input  logic                access,
  input  logic                lockout,
  output logic [CODE_W-1:0]   key_out,
  output logic                enter,
  output logic                busy,
  output logic [1:0]          count,
  output logic                entry_err,
  output logic [2:0]          dbg_state
);

  // Strobe semantics: digit_valid/clear/submit are single-cycle requests with no
  // back-pressure; they are acted on only in IDLE/ONE/TWO and dropped otherwise.
  // enter and entry_err are registered one-cycle pulses.

  logic [2:0]        state, state_nxt;
  logic [CODE_W-1:0] buffer, buffer_nxt, key_nxt;
  logic              err_nxt, enter_nxt, digit_ok;
  logic              run, restart, expired;

  assign run = (state == S_ONE) || (state == S_TWO);

  always_comb begin
    state_nxt  = state;
    buffer_nxt = buffer;
    key_nxt    = key_out;
    err_nxt    = 1'b0;
    enter_nxt  = 1'b0;
    digit_ok   = 1'b0;
    case (state)
      S_IDLE, S_ONE, S_TWO: begin
        if (access || lockout) begin
          state_nxt  = S_BLOCKED;
          buffer_nxt = '0;
        end else if (clear) begin
          state_nxt  = S_IDLE;
          buffer_nxt = '0;
        end else if (submit) begin
          if (state == S_TWO) begin
            state_nxt = S_SEND;
            key_nxt   = buffer;
            enter_nxt = 1'b1;
          end else begin
            state_nxt  = S_IDLE;
            buffer_nxt = '0;
            err_nxt    = 1'b1;
          end
        end else if (digit_valid) begin
          if (state == S_TWO) begin
            err_nxt = 1'b1;
          end else begin
            buffer_nxt = {buffer[NIBBLE_W-1:0], digit};
            state_nxt  = (state == S_IDLE) ? S_ONE : S_TWO;
            digit_ok   = 1'b1;
          end
        end else if (expired) begin
          state_nxt  = S_IDLE;
          buffer_nxt = '0;
          err_nxt    = 1'b1;
        end
      end
      S_SEND: begin
        state_nxt  = S_WAIT;
        buffer_nxt = '0;
      end
      S_WAIT: begin
        // The lock's registered response to enter is visible here.
        if (access || lockout) begin
          state_nxt  = S_BLOCKED;
          buffer_nxt = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_BLOCKED: begin
        if (!access && !lockout) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt  = S_IDLE;
        buffer_nxt = '0;
      end
    endcase
  end

  assign restart = digit_ok || !((state_nxt == S_ONE) || (state_nxt == S_TWO));

  entry_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .restart (restart),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      buffer    <= '0;
      key_out   <= '0;
      enter     <= 1'b0;
      entry_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      buffer    <= buffer_nxt;
      key_out   <= key_nxt;
      enter     <= enter_nxt;
      entry_err <= err_nxt;
    end
  end

  assign busy      = (state == S_SEND) || (state == S_WAIT) || (state == S_BLOCKED);
  assign count     = (state == S_ONE) ? 2'd1 : (state == S_TWO) ? 2'd2 : 2'd0;
  assign dbg_state = state;

endmodule
